// File: rtl/double_tokens_if.sv
// Token handshake bundle for double_tokens: one input token line plus the
// output token, backlog and loss-status signals.
interface double_tokens_if #(
    parameter int CNT_W = 4
) ();
    logic             a;
    logic             b;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             drop;
    logic             overflow;

    modport master (
        output a,
        input  b,
        input  pending,
        input  busy,
        input  drop,
        input  overflow
    );

    modport slave (
        input  a,
        output b,
        output pending,
        output busy,
        output drop,
        output overflow
    );
endinterface

// File: rtl/double_tokens.sv
// Token multiplier: each high cycle on a yields FACTOR single-cycle tokens on b,
// buffered through a saturating backlog counter that flags any discarded tokens.
module double_tokens #(
    parameter int FACTOR = 2,
    parameter int CNT_W  = 4
) (
    input  logic          clk,
    input  logic          rst,
    double_tokens_if.slave tok_io
);
    // Three guard bits keep cnt + FACTOR from wrapping for every legal setting.
    localparam int              AW          = CNT_W + 3;
    localparam logic [AW-1:0]   FACTOR_W    = AW'(FACTOR);
    localparam logic [AW-1:0]   MAX_PENDING = AW'((1 << CNT_W) - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             b_q, b_d;
    logic             drop_q, drop_d;
    logic             ovf_q, ovf_d;
    logic [AW-1:0]    avail;
    logic [AW-1:0]    rem;

    always_comb begin
        avail  = {3'b000, cnt_q} + (tok_io.a ? FACTOR_W : '0);
        b_d    = (avail != '0);
        rem    = avail - AW'(b_d);
        cnt_d  = rem[CNT_W-1:0];
        drop_d = 1'b0;
        ovf_d  = ovf_q;
        // Backlog beyond the counter range is lost; clamp and flag the loss.
        if (rem > MAX_PENDING) begin
            cnt_d  = MAX_PENDING[CNT_W-1:0];
            drop_d = 1'b1;
            ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            b_q    <= 1'b0;
            drop_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            b_q    <= b_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    assign tok_io.b        = b_q;
    assign tok_io.pending  = cnt_q;
    assign tok_io.busy     = b_q | (cnt_q != '0);
    assign tok_io.drop     = drop_q;
    assign tok_io.overflow = ovf_q;
endmodule

// File: tb/tb_double_tokens.sv
// Self-checking bench for double_tokens: two instances (FACTOR 2 and 3) share
// clock and reset; directed table, saturation, async reset and random traffic.
module tb_double_tokens;
    localparam int MAXP = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    double_tokens_if #(.CNT_W(4)) tok1 ();
    double_tokens_if #(.CNT_W(4)) tok2 ();

    double_tokens #(.FACTOR(2), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .tok_io(tok1));
    double_tokens #(.FACTOR(3), .CNT_W(4)) dut2 (.clk(clk), .rst(rst), .tok_io(tok2));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int   fac [2] = '{2, 3};
    int   m_cnt [2];
    logic m_b [2];
    logic m_drop [2];
    logic m_ovf [2];

    typedef struct {
        logic a;
        logic b2;
        int   p2;
        logic b3;
        int   p3;
    } vec_t;
    vec_t vecs [14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at t=%0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_b[i] = 1'b0; m_drop[i] = 1'b0; m_ovf[i] = 1'b0;
        end
    endtask

    // Reference: add FACTOR tokens on a, emit one if any exist, clamp the rest.
    task automatic model_edge(input logic av);
        for (int i = 0; i < 2; i++) begin
            int tot;
            tot = m_cnt[i];
            if (av) tot = tot + fac[i];
            m_b[i] = (tot > 0);
            if (tot > 0) tot = tot - 1;
            if (tot > MAXP) begin
                m_cnt[i] = MAXP; m_drop[i] = 1'b1; m_ovf[i] = 1'b1;
            end else begin
                m_cnt[i] = tot;  m_drop[i] = 1'b0;
            end
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_b1"},    int'(tok1.b),        int'(m_b[0]));
        chk({tag, "_pend1"}, int'(tok1.pending),  m_cnt[0]);
        chk({tag, "_drop1"}, int'(tok1.drop),     int'(m_drop[0]));
        chk({tag, "_ovf1"},  int'(tok1.overflow), int'(m_ovf[0]));
        chk({tag, "_busy1"}, int'(tok1.busy),     int'(m_b[0] || m_cnt[0] != 0));
        chk({tag, "_b2"},    int'(tok2.b),        int'(m_b[1]));
        chk({tag, "_pend2"}, int'(tok2.pending),  m_cnt[1]);
        chk({tag, "_drop2"}, int'(tok2.drop),     int'(m_drop[1]));
        chk({tag, "_ovf2"},  int'(tok2.overflow), int'(m_ovf[1]));
        chk({tag, "_busy2"}, int'(tok2.busy),     int'(m_b[1] || m_cnt[1] != 0));
    endtask

    // Starts and ends on a falling edge; a is applied before the rising edge.
    task automatic step(input logic av);
        tok1.a = av;
        tok2.a = av;
        @(posedge clk);
        model_edge(av);
        @(negedge clk);
        cyc++;
        $display("cyc %0d a=%0b | f2 b=%0b pend=%0d drop=%0b ovf=%0b | f3 b=%0b pend=%0d drop=%0b ovf=%0b",
                 cyc, av, tok1.b, tok1.pending, tok1.drop, tok1.overflow,
                 tok2.b, tok2.pending, tok2.drop, tok2.overflow);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_b1"},    int'(tok1.b),        0);
        chk({tag, "_pend1"}, int'(tok1.pending),  0);
        chk({tag, "_drop1"}, int'(tok1.drop),     0);
        chk({tag, "_ovf1"},  int'(tok1.overflow), 0);
        chk({tag, "_b2"},    int'(tok2.b),        0);
        chk({tag, "_pend2"}, int'(tok2.pending),  0);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int bcnt;
        int acnt;
        int bc [2];
        int seg_p, seg_len, done;
        logic av;

        // Directed single-token then burst-of-3 vectors, both factors.
        vecs[0]  = '{1'b1, 1'b1, 1, 1'b1, 2};
        vecs[1]  = '{1'b0, 1'b1, 0, 1'b1, 1};
        vecs[2]  = '{1'b0, 1'b0, 0, 1'b1, 0};
        vecs[3]  = '{1'b0, 1'b0, 0, 1'b0, 0};
        vecs[4]  = '{1'b1, 1'b1, 1, 1'b1, 2};
        vecs[5]  = '{1'b1, 1'b1, 2, 1'b1, 4};
        vecs[6]  = '{1'b1, 1'b1, 3, 1'b1, 6};
        vecs[7]  = '{1'b0, 1'b1, 2, 1'b1, 5};
        vecs[8]  = '{1'b0, 1'b1, 1, 1'b1, 4};
        vecs[9]  = '{1'b0, 1'b1, 0, 1'b1, 3};
        vecs[10] = '{1'b0, 1'b0, 0, 1'b1, 2};
        vecs[11] = '{1'b0, 1'b0, 0, 1'b1, 1};
        vecs[12] = '{1'b0, 1'b0, 0, 1'b1, 0};
        vecs[13] = '{1'b0, 1'b0, 0, 1'b0, 0};

        tok1.a = 1'b0;
        tok2.a = 1'b0;
        model_reset();

        // Reset held 50 time units with a toggling: outputs must stay zero.
        #1 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_all_zero("rst_hold");
            tok1.a = ~tok1.a;
            tok2.a = tok1.a;
        end
        tok1.a = 1'b0;
        tok2.a = 1'b0;
        rst = 1'b0;

        // Table-driven directed vectors.
        bcnt = 0;
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].a);
            chk("vec_b2",    int'(tok1.b),        int'(vecs[i].b2));
            chk("vec_pend2", int'(tok1.pending),  vecs[i].p2);
            chk("vec_busy2", int'(tok1.busy),     int'(vecs[i].b2 || vecs[i].p2 != 0));
            chk("vec_b3",    int'(tok2.b),        int'(vecs[i].b3));
            chk("vec_pend3", int'(tok2.pending),  vecs[i].p3);
            chk("vec_drop",  int'(tok1.drop | tok2.drop), 0);
            chk("vec_ovf",   int'(tok1.overflow | tok2.overflow), 0);
            if (i >= 4 && tok1.b) bcnt++;
        end
        chk("burst_b_count_f2", bcnt, 6);

        // Saturation: a held high 20 cycles.
        for (int n = 1; n <= 20; n++) begin
            step(1'b1);
            chk("sat_pend", int'(tok1.pending), (n < MAXP) ? n : MAXP);
            chk("sat_drop", int'(tok1.drop), int'(n >= 16));
            chk("sat_ovf",  int'(tok1.overflow), int'(n >= 16));
            chk("sat_b",    int'(tok1.b), 1);
            chk_model("sat");
        end
        bcnt = 1;
        done = 0;
        for (int n = 0; n < 40 && done == 0; n++) begin
            step(1'b0);
            chk_model("sat_drain");
            if (tok1.b) bcnt++;
            if (!tok1.busy && !tok2.busy) done = 1;
        end
        chk("sat_drain_done", done, 1);
        chk("sat_b_after_last", bcnt, 16);
        chk("sat_ovf_sticky", int'(tok1.overflow), 1);

        // Async reset mid-drain.
        for (int n = 0; n < 5; n++) step(1'b1);
        chk("mid_pend_before", int'(tok1.pending), 5);
        tok1.a = 1'b0;
        tok2.a = 1'b0;
        #2 rst = 1'b1;
        #1 chk_all_zero("mid_rst_async");
        chk("mid_rst_ovf2", int'(tok2.overflow), 0);
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_rst_release");
        for (int n = 0; n < 4; n++) begin
            step(1'b0);
            chk("mid_idle_b1", int'(tok1.b), 0);
            chk("mid_idle_b2", int'(tok2.b), 0);
        end
        step(1'b1);
        chk_model("mid_new_token");
        for (int n = 0; n < 4; n++) step(1'b0);
        chk_model("mid_new_drained");

        // Random traffic at mixed periods, checked against the model.
        pulse_reset();
        @(negedge clk);
        acnt = 0;
        bc[0] = 0;
        bc[1] = 0;
        cyc = 0;
        while (cyc < 100) begin
            seg_p   = $urandom_range(2, 5);
            seg_len = $urandom_range(5, 15);
            for (int k = 0; k < seg_len && cyc < 100; k++) begin
                av = ($urandom_range(0, seg_p - 1) == 0);
                step(av);
                if (av) acnt++;
                if (tok1.b) bc[0]++;
                if (tok2.b) bc[1]++;
                chk_model("rand");
            end
        end
        done = 0;
        for (int n = 0; n < 300 && done == 0; n++) begin
            step(1'b0);
            if (tok1.b) bc[0]++;
            if (tok2.b) bc[1]++;
            chk_model("rand_drain");
            if (!tok1.busy && !tok2.busy) done = 1;
        end
        chk("rand_drain_done", done, 1);
        if (!m_ovf[0]) chk("rand_conserve_f2", bc[0], 2 * acnt);
        if (!m_ovf[1]) chk("rand_conserve_f3", bc[1], 3 * acnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
